// File: rtl/digit_pkg.sv
// Shared constants for the time-of-day display: segment codes, counter limits, digit count.
package digit_pkg;

  // Active-low segment codes, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int N_DIGITS = 6;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchronizes a slow level input into clk_input and emits a one-cycle pulse per rising edge.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_input,
  input  logic rst_n,
  input  logic din,
  output logic tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk_input) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/digit_time_display.sv
// 24-hour BCD time-of-day counter with hour/minute set buttons and a six-digit
// common-anode scan driver.
module digit_time_display
  import digit_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_input,
  input  logic                rst_n,
  input  logic                sec_clk,
  input  logic                ms_1_clk,
  input  logic                inc_hour,
  input  logic                inc_min,
  output logic [N_DIGITS-1:0] an,
  output logic [7:0]          seg,
  output logic [23:0]         time_bcd
);

  logic sec_tick, ms_tick, hour_tick, min_tick;

  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sec  (.clk_input(clk_input), .rst_n(rst_n), .din(sec_clk),  .tick(sec_tick));
  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ms   (.clk_input(clk_input), .rst_n(rst_n), .din(ms_1_clk), .tick(ms_tick));
  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_hour (.clk_input(clk_input), .rst_n(rst_n), .din(inc_hour), .tick(hour_tick));
  tick_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min  (.clk_input(clk_input), .rst_n(rst_n), .din(inc_min),  .tick(min_tick));

  logic [3:0] s0, s1, m0, m1, h0, h1;
  logic [2:0] idx;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic       min_carry, hour_carry, min_adv, hour_adv;
  logic [3:0] scan_digit;
  logic [7:0] seg_next;

  assign sec_wrap  = (s1 == 4'(SEC_MAX / 10))  && (s0 == 4'(SEC_MAX % 10));
  assign min_wrap  = (m1 == 4'(MIN_MAX / 10))  && (m0 == 4'(MIN_MAX % 10));
  assign hour_wrap = (h1 == 4'(HOUR_MAX / 10)) && (h0 == 4'(HOUR_MAX % 10));

  // A carry and a button tick in the same cycle merge into a single advance.
  assign min_carry  = sec_tick & sec_wrap;
  assign hour_carry = min_carry & min_wrap;
  assign min_adv    = min_carry | min_tick;
  assign hour_adv   = hour_carry | hour_tick;

  always_comb begin
    scan_digit = 4'hF;
    case (idx)
      3'd0:    scan_digit = s0;
      3'd1:    scan_digit = s1;
      3'd2:    scan_digit = m0;
      3'd3:    scan_digit = m1;
      3'd4:    scan_digit = h0;
      3'd5:    scan_digit = h1;
      default: scan_digit = 4'hF;
    endcase
    seg_next = seg_decode(scan_digit);
    if (idx == 3'd2 || idx == 3'd4) seg_next[7] = 1'b0;
  end

  always_ff @(posedge clk_input) begin
    if (!rst_n) begin
      s0  <= 4'd0;
      s1  <= 4'd0;
      m0  <= 4'd0;
      m1  <= 4'd0;
      h0  <= 4'd0;
      h1  <= 4'd0;
      idx <= 3'd0;
      an  <= 6'b111110;
      seg <= SEG_0;
    end else begin
      if (sec_tick) begin
        if (s0 == 4'd9) begin
          s0 <= 4'd0;
          s1 <= sec_wrap ? 4'd0 : s1 + 4'd1;
        end else begin
          s0 <= s0 + 4'd1;
        end
      end
      if (min_adv) begin
        if (m0 == 4'd9) begin
          m0 <= 4'd0;
          m1 <= min_wrap ? 4'd0 : m1 + 4'd1;
        end else begin
          m0 <= m0 + 4'd1;
        end
      end
      if (hour_adv) begin
        if (hour_wrap) begin
          h0 <= 4'd0;
          h1 <= 4'd0;
        end else if (h0 == 4'd9) begin
          h0 <= 4'd0;
          h1 <= h1 + 4'd1;
        end else begin
          h0 <= h0 + 4'd1;
        end
      end
      // Indices 6 and 7 are unreachable; any out-of-range value recovers to 0.
      if (ms_tick) idx <= (idx >= 3'(N_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      an  <= ~(6'b000001 << idx);
      seg <= seg_next;
    end
  end

  assign time_bcd = {h1, h0, m1, m0, s1, s0};

endmodule

// File: tb/tb_digit_time_display.sv
// Self-checking bench for digit_time_display: directed sequences, a scan table and
// random button/tick mixes against an hours/minutes/seconds reference model.
module tb_digit_time_display;

  logic        clk_input = 1'b0;
  logic        rst_n     = 1'b0;
  logic        sec_clk   = 1'b0;
  logic        ms_1_clk  = 1'b0;
  logic        inc_hour  = 1'b0;
  logic        inc_min   = 1'b0;
  logic [5:0]  an;
  logic [7:0]  seg;
  logic [23:0] time_bcd;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: plain integers for time and scan position
  int r_h = 0, r_m = 0, r_s = 0, r_idx = 0;

  logic [7:0] seg_ref [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  typedef struct {
    int         n_ms;
    logic [5:0] an_exp;
    logic [7:0] seg_exp;
  } scan_vec_t;

  scan_vec_t scan_tab [8];

  digit_time_display #(.SYNC_STAGES(2)) dut (
    .clk_input(clk_input),
    .rst_n    (rst_n),
    .sec_clk  (sec_clk),
    .ms_1_clk (ms_1_clk),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .an       (an),
    .seg      (seg),
    .time_bcd (time_bcd)
  );

  always #5 clk_input = ~clk_input;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

  function automatic logic [23:0] ref_bcd();
    return {4'(r_h / 10), 4'(r_h % 10), 4'(r_m / 10), 4'(r_m % 10), 4'(r_s / 10), 4'(r_s % 10)};
  endfunction

  function automatic logic [7:0] ref_seg();
    int d;
    logic [7:0] r;
    case (r_idx)
      0: d = r_s % 10;
      1: d = r_s / 10;
      2: d = r_m % 10;
      3: d = r_m / 10;
      4: d = r_h % 10;
      default: d = r_h / 10;
    endcase
    r = seg_ref[d];
    if (r_idx == 2 || r_idx == 4) r[7] = 1'b0;
    return r;
  endfunction

  function automatic logic [5:0] ref_an();
    logic [5:0] a;
    a = 6'b111111;
    a[r_idx] = 1'b0;
    return a;
  endfunction

  task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, " time_bcd"}, time_bcd, ref_bcd());
    check({tag, " an"}, 24'(an), 24'(ref_an()));
    check({tag, " seg"}, 24'(seg), 24'(ref_seg()));
  endtask

  task automatic model_step(input bit s, input bit mi, input bit hr);
    bit carry_m, carry_h;
    carry_m = s && (r_s == 59);
    carry_h = 1'b0;
    if (s) r_s = (r_s + 1) % 60;
    if (carry_m || mi) begin
      carry_h = carry_m && (r_m == 59);
      r_m = (r_m + 1) % 60;
    end
    if (carry_h || hr) r_h = (r_h + 1) % 24;
  endtask

  // m: bit0 sec_clk, bit1 inc_min, bit2 inc_hour, bit3 ms_1_clk
  task automatic pulse(input logic [3:0] m, input int hi, input int lo);
    @(negedge clk_input);
    sec_clk = m[0]; inc_min = m[1]; inc_hour = m[2]; ms_1_clk = m[3];
    repeat (hi) @(negedge clk_input);
    sec_clk = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; ms_1_clk = 1'b0;
    repeat (lo - 1) @(negedge clk_input);
    model_step(m[0], m[1], m[2]);
    if (m[3]) r_idx = (r_idx + 1) % 6;
  endtask

  task automatic do_reset();
    @(negedge clk_input);
    rst_n = 1'b0;
    @(negedge clk_input);
    rst_n = 1'b1;
    r_h = 0; r_m = 0; r_s = 0; r_idx = 0;
  endtask

  task automatic set_time(input int h, input int mi, input int s);
    do_reset();
    repeat (h)  pulse(4'b0100, 2, 4);
    repeat (mi) pulse(4'b0010, 2, 4);
    repeat (s)  pulse(4'b0001, 2, 4);
  endtask

  initial begin
    scan_tab[0] = '{0, 6'b111110, 8'h82};
    scan_tab[1] = '{1, 6'b111101, 8'h92};
    scan_tab[2] = '{2, 6'b111011, 8'h19};
    scan_tab[3] = '{3, 6'b110111, 8'hB0};
    scan_tab[4] = '{4, 6'b101111, 8'h24};
    scan_tab[5] = '{5, 6'b011111, 8'hF9};
    scan_tab[6] = '{6, 6'b111110, 8'h82};
    scan_tab[7] = '{7, 6'b111101, 8'h92};

    // Reset held with inputs toggling
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_input);
      check("reset time_bcd", time_bcd, 24'h000000);
      check("reset an", 24'(an), 24'(6'b111110));
      check("reset seg", 24'(seg), 24'(8'hC0));
      sec_clk = ~sec_clk; inc_min = ~inc_min; inc_hour = k[0]; ms_1_clk = ~ms_1_clk;
    end
    @(negedge clk_input);
    sec_clk = 1'b0; inc_min = 1'b0; inc_hour = 1'b0; ms_1_clk = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk_input);
    check("idle time_bcd", time_bcd, 24'h000000);
    check_all("idle");

    // Seconds counting
    repeat (10) pulse(4'b0001, 2, 4);
    check("ten seconds", time_bcd, 24'h000010);
    repeat (50) pulse(4'b0001, 2, 4);
    check("sixty seconds", time_bcd, 24'h000100);
    check_all("sixty seconds");

    // Full rollover
    set_time(23, 59, 59);
    check("pre-rollover", time_bcd, 24'h235959);
    pulse(4'b0001, 2, 4);
    check("rollover", time_bcd, 24'h000000);
    check_all("rollover");

    // Button wraps do not carry
    repeat (5)  pulse(4'b0100, 2, 4);
    repeat (59) pulse(4'b0010, 2, 4);
    check("min at 59", time_bcd, 24'h055900);
    pulse(4'b0010, 2, 4);
    check("inc_min wrap", time_bcd, 24'h050000);
    repeat (19) pulse(4'b0100, 2, 4);
    check("inc_hour wrap", time_bcd, 24'h000000);

    // Scan sequence at 12:34:56
    set_time(12, 34, 56);
    begin
      int applied;
      applied = 0;
      for (int v = 0; v < 8; v++) begin
        while (applied < scan_tab[v].n_ms) begin
          pulse(4'b1000, 2, 4);
          applied++;
        end
        check($sformatf("scan %0d an", v), 24'(an), 24'(scan_tab[v].an_exp));
        check($sformatf("scan %0d seg", v), 24'(seg), 24'(scan_tab[v].seg_exp));
      end
    end
    check_all("scan model");

    // Simultaneous carry and button ticks
    set_time(0, 5, 59);
    pulse(4'b0011, 2, 4);
    check("sec+inc_min", time_bcd, 24'h000600);
    set_time(3, 59, 59);
    pulse(4'b0101, 2, 4);
    check("sec+inc_hour", time_bcd, 24'h040000);
    set_time(7, 59, 59);
    pulse(4'b0111, 2, 4);
    check("sec+min+hour", time_bcd, 24'h080000);
    check_all("sec+min+hour");

    // Mid-operation reset
    set_time(10, 20, 30);
    repeat (3) pulse(4'b1000, 2, 4);
    check("pre-reset an", 24'(an), 24'(6'b110111));
    check("pre-reset time", time_bcd, 24'h102030);
    @(negedge clk_input);
    rst_n = 1'b0;
    @(negedge clk_input);
    rst_n = 1'b1;
    r_h = 0; r_m = 0; r_s = 0; r_idx = 0;
    check("mid-reset time", time_bcd, 24'h000000);
    check("mid-reset an", 24'(an), 24'(6'b111110));
    check("mid-reset seg", 24'(seg), 24'(8'hC0));
    pulse(4'b0001, 2, 4);
    check("resume", time_bcd, 24'h000001);

    // Back-to-back fast edges: one rising edge every two cycles
    repeat (20) pulse(4'b0001, 1, 1);
    repeat (13) pulse(4'b1000, 1, 1);
    repeat (5) @(negedge clk_input);
    check_all("fast burst");

    // Random mixes from near a day boundary
    set_time(23, 58, 40);
    for (int n = 0; n < 200; n++) begin
      logic [3:0] m;
      m = 4'($urandom_range(1, 15));
      pulse(m, 2, 4);
      check_all($sformatf("rand %0d m=%b", n, m));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
